muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer sitting in EX beside the main ALU.
- Accepts an operation when the ALU decode flags an M-extension instruction (is_muldiv, with the 3-bit muldiv_op taken from funct3).
- Runs a 32-step shift-add multiply or restoring divide, holds the pipeline stalled while busy, and returns a 32-bit result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN; only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  EX-stage valid M-extension instruction (is_muldiv qualified by stage valid)
- muldiv_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value
- op_b  input  XLEN  rs2 value
- flush  input  1  pipeline kill; aborts any operation in flight
- stall  output  1  freezes IF/ID/EX while asserted
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  XLEN  registered result

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low on rst_n.
- Reset values:
  - state=IDLE, done=0, result=0, counter=0, internal accumulators 0.
  - stall is forced 0 while rst_n=0.
  - Reset mid-operation discards the operation; no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and a special case applies: load result directly, go to DONE.
  - start=1 otherwise: latch op, operand magnitudes and sign flags; counter=0; go to CALC.
- CALC:
  - One iteration per cycle; counter increments.
  - After the iteration with counter==XLEN-1, go to FIX.
- FIX: apply sign correction, select the output word, register result, go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Stall: stall = (IDLE and start) or CALC or FIX. stall is 0 in DONE, so the pipeline advances while result is valid.
- start is ignored in CALC, FIX and DONE.
- flush:
  - Takes priority over start.
  - In any state: next state is IDLE, done stays 0, result unchanged.
  - In IDLE, a start in the same cycle is dropped.
- Latency:
  - Normal path: start high in cycle 0 gives done in cycle XLEN+2 (cycle 34).
  - Special case: done in cycle 1.
- Multiply:
  - Operand signedness:
    - MUL/MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU: both unsigned.
  - Compute the unsigned 2*XLEN product of the magnitudes.
  - Negate the 2*XLEN product in FIX when the operand signs differ.
  - MUL returns the low word; the other three return the high word.
- Divide:
  - Signed ops use magnitudes.
  - Restoring division: 1 quotient bit per cycle, remainder XLEN+1 bits wide.
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
- Special cases (fast path, no CALC):
  - op_b==0: DIV/DIVU return all ones. REM/REMU return op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
  - Multiply by zero is not special-cased; it takes the full path.
- Operand stability: op_a, op_b and muldiv_op are sampled only at acceptance. Later changes have no effect.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), start pulse at cycle 0 -> stall high cycles 0-33; done=1 and result=0xFFFFFFEB at cycle 34; stall=0 at cycle 34.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 0x10000*0x10000 -> 0.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each completes at cycle 34.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. All fast path: done at cycle 1, stall only in cycle 0.
- Flush at cycle 10 of a DIV -> IDLE at cycle 11, no done pulse, result holds its prior value; a new MUL 3*4 started afterwards -> 12.
- rst_n=0 for one cycle mid-CALC -> state IDLE, done=0, result=0, stall=0; back-to-back ops (new start the cycle after DONE) each complete correctly.

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      muldiv_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed, b_signed, sign_a, sign_b, is_div, div_zero, div_ovf;
    logic [XLEN-1:0]     mag_a, mag_b, quo_fix, rem_fix;
    logic [XLEN:0]       mul_sum, rem_sh;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   prod_fix;

    always_comb begin
        case (muldiv_op)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         begin a_signed = 1'b1; b_signed = 1'b0; end
            default:                        begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
        sign_a   = a_signed & op_a[XLEN-1];
        sign_b   = b_signed & op_b[XLEN-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        is_div   = muldiv_op[2];
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !muldiv_op[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (op_b == {XLEN{1'b1}});

        // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        // Divide: dividend bits shift out of acc's low word, quotient bits shift in behind them.
        rem_sh   = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, b_q};

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            result_d = muldiv_op[1] ? op_a : {XLEN{1'b1}};
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = muldiv_op[1] ? '0 : op_a;
                            state_d  = S_DONE;
                        end else begin
                            op_d    = muldiv_op;
                            a_d     = mag_a;
                            b_d     = mag_b;
                            acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                            rem_d   = '0;
                            cnt_d   = '0;
                            neg_d   = (is_div && muldiv_op[1]) ? sign_a : (sign_a ^ sign_b);
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (op_q[2]) begin
                        rem_d = div_diff[XLEN+1] ? rem_sh : div_diff[XLEN:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN+1]};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
                end
                S_FIX: begin
                    case (op_q)
                        3'b000:         result_d = prod_fix[XLEN-1:0];
                        3'b100, 3'b101: result_d = quo_fix;
                        3'b110, 3'b111: result_d = rem_fix;
                        default:        result_d = prod_fix[2*XLEN-1:XLEN];
                    endcase
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign stall  = rst_n & (((state_q == S_IDLE) & start) | (state_q == S_CALC) | (state_q == S_FIX));
    assign done   = (state_q == S_DONE);
    assign result = result_q;
endmodule
